// File: rtl/vector_alu.sv
// Lane-parallel SIMD integer ALU: VECTOR lanes of BUS bits, registered result and per-lane flag.
// Optional saturating mode when VECTOR_ALU_SAT_EN is defined; wrapping arithmetic otherwise.
module vector_alu #(
  parameter int unsigned VECTOR       = 4,
  parameter int unsigned BUS          = 4,
  parameter int unsigned BUS_SELECTOR = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [VECTOR-1:0][BUS-1:0]    a,
  input  logic [VECTOR-1:0][BUS-1:0]    b,
  input  logic [BUS_SELECTOR-1:0]       selector,
  output logic                          out_valid,
  output logic [VECTOR-1:0][BUS-1:0]    result,
  output logic [VECTOR-1:0]             carry_out
);

  localparam int unsigned SumW  = BUS + 1;
  localparam int unsigned ProdW = 2 * BUS;

  typedef enum logic [1:0] {OpAdd, OpSub, OpMul, OpRsv} op_e;

  op_e op;
  assign op = op_e'(selector[1:0]);

  // Upper selector bits are deliberately ignored.
  logic unused_sel;
  assign unused_sel = ^selector;

  logic [VECTOR-1:0][BUS-1:0] lane_res;
  logic [VECTOR-1:0]          lane_flag;

  for (genvar i = 0; i < VECTOR; i++) begin : g_lane
    logic             sub;
    logic [BUS-1:0]   b_eff;
    logic [SumW-1:0]  sum;
    logic [ProdW-1:0] prod;
    logic             add_carry;
    logic             sub_borrow;
    logic             mul_ovf;
    logic [BUS-1:0]   res;
    logic             flag;

    // ADD and SUB share one adder: SUB is a + ~b + 1, whose carry-out is the inverted borrow.
    assign sub        = (op == OpSub);
    assign b_eff      = sub ? ~b[i] : b[i];
    assign sum        = {1'b0, a[i]} + {1'b0, b_eff} + SumW'(sub);
    assign prod       = ProdW'(a[i]) * ProdW'(b[i]);
    assign add_carry  = sum[BUS];
    assign sub_borrow = ~sum[BUS];
    assign mul_ovf    = |prod[ProdW-1:BUS];

    always_comb begin
      flag = 1'b0;
      unique case (op)
        OpAdd:   flag = add_carry;
        OpSub:   flag = sub_borrow;
        OpMul:   flag = mul_ovf;
        default: flag = 1'b0;
      endcase
    end

    always_comb begin
      res = '0;
      unique case (op)
`ifdef VECTOR_ALU_SAT_EN
        OpAdd:   res = add_carry  ? '1 : sum[BUS-1:0];
        OpSub:   res = sub_borrow ? '0 : sum[BUS-1:0];
        OpMul:   res = mul_ovf    ? '1 : prod[BUS-1:0];
`else
        OpAdd:   res = sum[BUS-1:0];
        OpSub:   res = sum[BUS-1:0];
        OpMul:   res = prod[BUS-1:0];
`endif
        default: res = '0;
      endcase
    end

    assign lane_res[i]  = res;
    assign lane_flag[i] = flag;
  end

  logic                       valid_d, valid_q;
  logic [VECTOR-1:0][BUS-1:0] result_d, result_q;
  logic [VECTOR-1:0]          carry_d, carry_q;

  always_comb begin
    valid_d  = in_valid;
    result_d = result_q;
    carry_d  = carry_q;
    if (in_valid) begin
      result_d = lane_res;
      carry_d  = lane_flag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_vector_alu.sv
// Self-checking bench for vector_alu: directed cases plus randomized traffic against a lane model.
// Expectations follow VECTOR_ALU_SAT_EN when it is defined.
module tb_vector_alu;

  localparam int V  = 4;
  localparam int W  = 4;
  localparam int S  = 4;
  localparam int VW = V * W;

  typedef logic [V-1:0][W-1:0] vec_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  vec_t          a;
  vec_t          b;
  logic [S-1:0]  selector;
  logic          out_valid;
  vec_t          result;
  logic [V-1:0]  carry_out;

  int n_tests;
  int n_fail;

  vector_alu #(
    .VECTOR      (V),
    .BUS         (W),
    .BUS_SELECTOR(S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .selector (selector),
    .out_valid(out_valid),
    .result   (result),
    .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: per-lane integer arithmetic straight from the operation rules.
  task automatic model(input vec_t ma, input vec_t mb, input int op,
                       output vec_t r, output logic [V-1:0] f);
    int x, y, t, m;
    m = 1 << W;
    r = '0;
    f = '0;
    for (int i = 0; i < V; i++) begin
      x = int'(ma[i]);
      y = int'(mb[i]);
      case (op)
        0: begin
          t = x + y;
          f[i] = (t >= m);
          r[i] = W'(t % m);
`ifdef VECTOR_ALU_SAT_EN
          if (f[i]) r[i] = W'(m - 1);
`endif
        end
        1: begin
          t = x - y;
          f[i] = (x < y);
          r[i] = W'((t + m) % m);
`ifdef VECTOR_ALU_SAT_EN
          if (f[i]) r[i] = '0;
`endif
        end
        2: begin
          t = x * y;
          f[i] = (t >= m);
          r[i] = W'(t % m);
`ifdef VECTOR_ALU_SAT_EN
          if (f[i]) r[i] = W'(m - 1);
`endif
        end
        default: begin
          r[i] = '0;
          f[i] = 1'b0;
        end
      endcase
    end
  endtask

  task automatic drive(input vec_t ta, input vec_t tb, input logic [S-1:0] sel);
    @(negedge clk);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    selector = sel;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    selector = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, carry_out, result} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: valid=%b carry=%b result=%h, want 0 0 0000",
               out_valid, carry_out, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Load a nonzero result, then assert reset mid-cycle with another op in flight.
    drive({4'd7, 4'd7, 4'd7, 4'd7}, {4'd8, 4'd9, 4'd1, 4'd2}, 4'd0);
    @(posedge clk);
    drive({4'd5, 4'd5, 4'd5, 4'd5}, {4'd1, 4'd1, 4'd1, 4'd1}, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, carry_out, result} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b carry=%b result=%h, want 0 0 0000",
               out_valid, carry_out, result);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, carry_out, result} !== '0) begin
      n_fail++;
      $display("FAIL reset_held: valid=%b carry=%b result=%h, want 0 0 0000",
               out_valid, carry_out, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = {4'd1, 4'd1, 4'd1, 4'd1};
    b = {4'd2, 4'd2, 4'd2, 4'd2};
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, carry_out, result} !== {1'b1, 4'b0000, 16'h3333}) begin
      n_fail++;
      $display("FAIL reset_first_op: valid=%b carry=%b result=%h, want 1 0000 3333",
               out_valid, carry_out, result);
    end
  endtask

  task automatic test_add();
    vec_t er;
`ifdef VECTOR_ALU_SAT_EN
    er = {4'd8, 4'd11, 4'd14, 4'd15};
`else
    er = {4'd8, 4'd11, 4'd14, 4'd1};
`endif
    drive({4'd0, 4'd3, 4'd6, 4'd9}, {4'd8, 4'd8, 4'd8, 4'd8}, 4'd0);
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, carry_out, result} !== {1'b1, 4'b0001, er}) begin
      n_fail++;
      $display("FAIL add: valid=%b carry=%b result=%h, want 1 0001 %h",
               out_valid, carry_out, result, er);
    end
  endtask

  task automatic test_sub();
    vec_t er;
`ifdef VECTOR_ALU_SAT_EN
    er = {4'd0, 4'd0, 4'd0, 4'd15};
`else
    er = {4'd14, 4'd0, 4'd15, 4'd15};
`endif
    drive({4'd3, 4'd5, 4'd0, 4'd15}, {4'd5, 4'd5, 4'd1, 4'd0}, 4'd1);
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, carry_out, result} !== {1'b1, 4'b1010, er}) begin
      n_fail++;
      $display("FAIL sub: valid=%b carry=%b result=%h, want 1 1010 %h",
               out_valid, carry_out, result, er);
    end
  endtask

  task automatic test_mul();
    vec_t er;
`ifdef VECTOR_ALU_SAT_EN
    er = {4'd15, 4'd15, 4'd15, 4'd0};
`else
    er = {4'd4, 4'd15, 4'd1, 4'd0};
`endif
    drive({4'd5, 4'd3, 4'd15, 4'd0}, {4'd4, 4'd5, 4'd15, 4'd7}, 4'd2);
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, carry_out, result} !== {1'b1, 4'b1010, er}) begin
      n_fail++;
      $display("FAIL mul: valid=%b carry=%b result=%h, want 1 1010 %h",
               out_valid, carry_out, result, er);
    end
  endtask

  task automatic test_selector();
    vec_t er;
    drive({4'd15, 4'd9, 4'd4, 4'd1}, {4'd15, 4'd8, 4'd3, 4'd2}, 4'b1111);
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, carry_out, result} !== {1'b1, 4'b0000, 16'h0000}) begin
      n_fail++;
      $display("FAIL reserved: valid=%b carry=%b result=%h, want 1 0000 0000",
               out_valid, carry_out, result);
    end
`ifdef VECTOR_ALU_SAT_EN
    er = {4'd15, 4'd15, 4'd7, 4'd3};
`else
    er = {4'd14, 4'd1, 4'd7, 4'd3};
`endif
    drive({4'd15, 4'd9, 4'd4, 4'd1}, {4'd15, 4'd8, 4'd3, 4'd2}, 4'b0100);
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, carry_out, result} !== {1'b1, 4'b1100, er}) begin
      n_fail++;
      $display("FAIL sel_upper_ignored: valid=%b carry=%b result=%h, want 1 1100 %h",
               out_valid, carry_out, result, er);
    end
  endtask

  task automatic test_back_to_back();
    vec_t         ta, tb, er, held_r;
    logic [V-1:0] ef, held_f;
    held_r = '0;
    held_f = '0;
    for (int op = 0; op < 3; op++) begin
      ta = VW'($urandom);
      tb = VW'($urandom);
      model(ta, tb, op, er, ef);
      drive(ta, tb, S'(op));
      @(posedge clk);
      #1;
      n_tests++;
      if ({out_valid, carry_out, result} !== {1'b1, ef, er}) begin
        n_fail++;
        $display("FAIL b2b_op%0d: valid=%b carry=%b result=%h, want 1 %b %h",
                 op, out_valid, carry_out, result, ef, er);
      end
      held_r = er;
      held_f = ef;
    end
    @(negedge clk);
    in_valid = 1'b0;
    a        = VW'($urandom);
    b        = VW'($urandom);
    selector = '0;
    repeat (2) begin
      @(posedge clk);
      #1;
      n_tests++;
      if ({out_valid, carry_out, result} !== {1'b0, held_f, held_r}) begin
        n_fail++;
        $display("FAIL hold: valid=%b carry=%b result=%h, want 0 %b %h",
                 out_valid, carry_out, result, held_f, held_r);
      end
    end
  endtask

  task automatic test_random();
    vec_t         ta, tb, er, ef_r;
    logic [V-1:0] ef, exp_f;
    logic         exp_v;
    logic [S-1:0] sel;
    vec_t         exp_r;
    exp_r = result;
    exp_f = carry_out;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      ta       = VW'($urandom);
      tb       = VW'($urandom);
      sel      = S'($urandom);
      in_valid = ($urandom_range(3) != 0);
      a        = ta;
      b        = tb;
      selector = sel;
      exp_v    = in_valid;
      if (in_valid) begin
        model(ta, tb, int'(sel[1:0]), er, ef);
        exp_r = er;
        exp_f = ef;
      end
      ef_r = exp_r;
      @(posedge clk);
      #1;
      n_tests++;
      if ({out_valid, carry_out, result} !== {exp_v, exp_f, ef_r}) begin
        n_fail++;
        $display("FAIL random_%0d: sel=%h a=%h b=%h valid=%b carry=%b result=%h, want %b %b %h",
                 n, sel, ta, tb, out_valid, carry_out, result, exp_v, exp_f, ef_r);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_selector();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
